// File: rtl/tnn_enc_pkg.sv
// rtl/tnn_enc_pkg.sv - shared types and constants for the TNN feature encoder
package tnn_enc_pkg;

  localparam int CODE_W     = 2;
  localparam int NTHR       = 3;
  localparam int NFEAT_DEF  = 5;
  localparam int FEAT_W_DEF = 8;

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  typedef logic [FEAT_W_DEF-1:0] thr_t;

  // Feature f owns bits [3*FEAT_W*f +: 3*FEAT_W]; T1 sits in the lowest byte.
  localparam logic [NTHR*FEAT_W_DEF*NFEAT_DEF-1:0] THR_INIT_DEF =
    {NFEAT_DEF{thr_t'(8'd64), thr_t'(8'd128), thr_t'(8'd192)}};

endpackage

// File: rtl/tnn_quant2b.sv
// rtl/tnn_quant2b.sv - 2-bit quantizer: count of thresholds at or below x
module tnn_quant2b
  import tnn_enc_pkg::*;
#(
  parameter int FEAT_W = 8
) (
  input  logic [FEAT_W-1:0] x,
  input  logic [FEAT_W-1:0] t1,
  input  logic [FEAT_W-1:0] t2,
  input  logic [FEAT_W-1:0] t3,
  output logic [CODE_W-1:0] code
);

  logic ge1, ge2, ge3;

  assign ge1  = (x >= t1);
  assign ge2  = (x >= t2);
  assign ge3  = (x >= t3);
  // Sum rather than priority encode so unordered thresholds stay well defined.
  assign code = CODE_W'(ge1) + CODE_W'(ge2) + CODE_W'(ge3);

endmodule

// File: rtl/tnn_feature_encoder.sv
// rtl/tnn_feature_encoder.sv - serial feature stream to 2-bit code vector; TNN_ENC_THR_CFG_EN adds threshold write port
module tnn_feature_encoder
  import tnn_enc_pkg::*;
#(
  parameter int NFEAT  = 5,
  parameter int FEAT_W = 8,
  parameter int CNT_W  = 16,
  parameter logic [NTHR*FEAT_W*NFEAT-1:0] THR_INIT = THR_INIT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef TNN_ENC_THR_CFG_EN
  input  logic                     cfg_we,
  input  logic [2:0]               cfg_feat,
  input  logic [1:0]               cfg_sel,
  input  logic [FEAT_W-1:0]        cfg_data,
`endif
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [FEAT_W-1:0]        s_data,
  input  logic                     s_last,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [CODE_W*NFEAT-1:0]  m_vec,
  output logic                     err_frame,
  output logic [CNT_W-1:0]         vec_cnt
);

  localparam int IDX_W = (NFEAT > 1) ? $clog2(NFEAT) : 1;

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [FEAT_W-1:0]   thr [NFEAT*NTHR];
  logic [FEAT_W-1:0]   t1, t2, t3;
  logic [CODE_W-1:0]   code;

`ifdef TNN_ENC_THR_CFG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NFEAT*NTHR; i++) thr[i] <= THR_INIT[FEAT_W*i +: FEAT_W];
    end else if (cfg_we) begin
      // Out-of-range feature or sel==3 simply matches no slot.
      for (int f = 0; f < NFEAT; f++)
        for (int k = 0; k < NTHR; k++)
          if (cfg_feat == 3'(f) && cfg_sel == 2'(k)) thr[NTHR*f+k] <= cfg_data;
    end
  end
`else
  always_comb begin
    for (int i = 0; i < NFEAT*NTHR; i++) thr[i] = THR_INIT[FEAT_W*i +: FEAT_W];
  end
`endif

  always_comb begin
    t1 = '0;
    t2 = '0;
    t3 = '0;
    for (int f = 0; f < NFEAT; f++) begin
      if (idx == IDX_W'(f)) begin
        t1 = thr[NTHR*f];
        t2 = thr[NTHR*f+1];
        t3 = thr[NTHR*f+2];
      end
    end
  end

  tnn_quant2b #(.FEAT_W(FEAT_W)) u_quant (
    .x    (s_data),
    .t1   (t1),
    .t2   (t2),
    .t3   (t3),
    .code (code)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= COLLECT;
      idx       <= '0;
      s_ready   <= 1'b1;
      m_valid   <= 1'b0;
      m_vec     <= '0;
      err_frame <= 1'b0;
      vec_cnt   <= '0;
    end else begin
      case (state)
        COLLECT: begin
          if (s_valid && s_ready) begin
            for (int f = 0; f < NFEAT; f++)
              if (idx == IDX_W'(f)) m_vec[CODE_W*f +: CODE_W] <= code;
            if (idx == IDX_W'(NFEAT-1)) begin
              state   <= HOLD;
              m_valid <= 1'b1;
              s_ready <= 1'b0;
              idx     <= '0;
              if (!s_last) err_frame <= 1'b1;
            end else if (s_last) begin
              idx       <= '0;
              err_frame <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          if (m_ready) begin
            state   <= COLLECT;
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            vec_cnt <= vec_cnt + CNT_W'(1);
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule
